// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) arithmetic helpers.
// The multiplier is an unrolled xtime chain, so it reduces to XOR gates.
package aes_pkg;

    localparam logic [7:0] POLY = 8'h1B;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    function automatic byte_t xtime(input byte_t a);
        xtime = a[7] ? ((a << 1) ^ POLY) : (a << 1);
    endfunction

    // Multiply by a small constant k (at most 4 bits wide).
    function automatic byte_t gf_mul(input byte_t a, input logic [3:0] k);
        byte_t x2;
        byte_t x4;
        byte_t x8;
        byte_t acc;
        x2  = xtime(a);
        x4  = xtime(x2);
        x8  = xtime(x4);
        acc = 8'h00;
        if (k[0]) acc = acc ^ a;
        if (k[1]) acc = acc ^ x2;
        if (k[2]) acc = acc ^ x4;
        if (k[3]) acc = acc ^ x8;
        gf_mul = acc;
    endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns for one 32-bit column.
// Byte 0 of the column sits in the MSBs.
module inv_mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    byte_t a0;
    byte_t a1;
    byte_t a2;
    byte_t a3;
    byte_t b0;
    byte_t b1;
    byte_t b2;
    byte_t b3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // Circulant matrix rows {0e,0b,0d,09}, rotated right per output byte.
    assign b0 = gf_mul(a0, 4'hE) ^ gf_mul(a1, 4'hB)
              ^ gf_mul(a2, 4'hD) ^ gf_mul(a3, 4'h9);
    assign b1 = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'hE)
              ^ gf_mul(a2, 4'hB) ^ gf_mul(a3, 4'hD);
    assign b2 = gf_mul(a0, 4'hD) ^ gf_mul(a1, 4'h9)
              ^ gf_mul(a2, 4'hE) ^ gf_mul(a3, 4'hB);
    assign b3 = gf_mul(a0, 4'hB) ^ gf_mul(a1, 4'hD)
              ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'hE);

    assign col_out = {b0, b1, b2, b3};

endmodule

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns over a full 128-bit state, one state per cycle.
// Four parallel column units feed a single output register stage.
module inv_mix_columns
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [127:0] state_in,
    output logic         out_valid,
    output logic [127:0] state_out
);

    state_t mixed;

    // Column c occupies bits [127-32c -: 32].
    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_mix_single_column u_col (
            .col_in  (state_in[127-32*c -: 32]),
            .col_out (mixed[127-32*c -: 32])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            state_out <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                state_out <= mixed;
            end
        end
    end

endmodule

// File: tb/tb_inv_mix_columns.sv
// Directed and round-trip checks for inv_mix_columns.
// Round trip feeds MixColumns(x) from a bit-serial GF model and expects x.
module tb_inv_mix_columns;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] state_in;
    logic         out_valid;
    logic [127:0] state_out;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_ffffffff_00000000;
    localparam logic [127:0] E2 = 128'hd4d4d4d5_2d26314c_ffffffff_00000000;

    inv_mix_columns dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .state_in  (state_in),
        .out_valid (out_valid),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
            r[103-32*c -: 8] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] x;
        logic [127:0] held;

        rst      = 1'b1;
        in_valid = 1'b0;
        state_in = '0;

        #3;
        chk("reset_state", state_out, 128'h0);
        chk("reset_valid", {127'h0, out_valid}, 128'h0);

        // Input during reset must be discarded.
        in_valid = 1'b1;
        state_in = V1;
        tick();
        chk("reset_discard_state", state_out, 128'h0);
        chk("reset_discard_valid", {127'h0, out_valid}, 128'h0);

        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        state_in = V1;
        tick();
        chk("vec1_state", state_out, E1);
        chk("vec1_valid", {127'h0, out_valid}, 128'h1);

        state_in = V2;
        tick();
        chk("vec2_state", state_out, E2);
        chk("vec2_valid", {127'h0, out_valid}, 128'h1);

        // Back-to-back pair.
        state_in = V1;
        tick();
        chk("b2b_first_state", state_out, E1);
        chk("b2b_first_valid", {127'h0, out_valid}, 128'h1);
        state_in = V2;
        tick();
        chk("b2b_second_state", state_out, E2);
        chk("b2b_second_valid", {127'h0, out_valid}, 128'h1);

        // Hold while idle with changing input.
        in_valid = 1'b0;
        held = E2;
        for (int i = 0; i < 4; i++) begin
            state_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("hold_state", state_out, held);
            chk("hold_valid", {127'h0, out_valid}, 128'h0);
        end

        // Round trip, streaming every cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            state_in = mix(x);
            tick();
            chk("roundtrip_state", state_out, x);
            chk("roundtrip_valid", {127'h0, out_valid}, 128'h1);
        end

        // Asynchronous reset while out_valid is high.
        state_in = V1;
        tick();
        chk("pre_reset_state", state_out, E1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_state", state_out, 128'h0);
        chk("async_reset_valid", {127'h0, out_valid}, 128'h0);
        state_in = V2;
        tick();
        chk("reset_held_state", state_out, 128'h0);
        chk("reset_held_valid", {127'h0, out_valid}, 128'h0);

        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("post_reset_idle_state", state_out, 128'h0);
        chk("post_reset_idle_valid", {127'h0, out_valid}, 128'h0);

        in_valid = 1'b1;
        state_in = V2;
        tick();
        chk("post_reset_vec_state", state_out, E2);
        chk("post_reset_vec_valid", {127'h0, out_valid}, 128'h1);
        in_valid = 1'b0;
        tick();
        chk("single_pulse_valid", {127'h0, out_valid}, 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
